// File: rtl/gaplus_pkg.sv
// Shared definitions for the GAPLUS ROM download sender.
//   ROM_AW  : width of the byte address on the ROM download bus
//   state_t : serialiser FSM states
package gaplus_pkg;
    localparam int ROM_AW = 18;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        SEND = 2'd2,
        GAP  = 2'd3
    } state_t;
endpackage

// File: rtl/gaplus_word_fifo.sv
// Synchronous word FIFO with flush.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   flush         empties the FIFO; a push in the same cycle lands after the flush
//   push, wdata   write request and data (ignored when full unless a pop happens)
//   pop, rdata    read request and head-of-queue data (rdata is the current head)
//   full, empty   occupancy flags
module gaplus_word_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;
    logic             wen;
    logic [AW-1:0]    waddr;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push on full is still taken.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    // During a flush the pointers restart at zero, so the surviving push goes to slot 0.
    assign wen   = flush ? push : do_push;
    assign waddr = flush ? '0 : wptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            rptr  <= '0;
            wptr  <= push ? AW'(1) : '0;
            count <= push ? (AW+1)'(1) : '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wen) mem[waddr] <= wdata;
    end
endmodule

// File: rtl/gaplus_rom_sender.sv
// Source end of the ROM download bus. Accepts 32-bit bridge writes, buffers them in a word
// FIFO and serialises each word as four big-endian byte strobes on ROMAD/ROMDT/ROMEN.
// Ports:
//   MCLK, RESET        master clock, asynchronous active-high reset
//   BR_WR/ADDR/DATA    bridge word write (byte address, bits[1:0] ignored)
//   DL_START, DL_END   download framing pulses
//   ROMCL              copy of MCLK for the loaders
//   ROMAD/ROMDT/ROMEN  byte bus; ROMAD/ROMDT valid whenever ROMEN=1, held between strobes
//   DL_ACTIVE/DL_DONE  download progress
//   OVERFLOW           sticky, a write was dropped on a full FIFO
//   dbg_state          current FSM state
module gaplus_rom_sender
    import gaplus_pkg::*;
#(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned ROM_BYTES  = 262144,
    parameter int          BYTE_GAP   = 3
) (
    input  logic              MCLK,
    input  logic              RESET,
    input  logic              BR_WR,
    input  logic [31:0]       BR_ADDR,
    input  logic [31:0]       BR_DATA,
    input  logic              DL_START,
    input  logic              DL_END,
    output logic              ROMCL,
    output logic [ROM_AW-1:0] ROMAD,
    output logic [7:0]        ROMDT,
    output logic              ROMEN,
    output logic              DL_ACTIVE,
    output logic              DL_DONE,
    output logic              OVERFLOW,
    output state_t            dbg_state
);
    localparam int EW = ROM_AW - 2 + 32;   // FIFO entry: {word offset, data}
    localparam int GW = (BYTE_GAP > 1) ? $clog2(BYTE_GAP) : 1;

    state_t         state, state_next;
    logic [1:0]     k, k_next;
    logic [GW-1:0]  gap_cnt;
    logic           gap_last;
    logic           load_byte;
    logic [31:0]    off;
    logic           in_range;
    logic           pop_now;
    logic           push_ok;
    logic           overflow_evt;
    logic           full, empty;
    logic [EW-1:0]  head, hold, src;
    logic [7:0]     byte_next;
    logic           end_flag;

    assign ROMCL     = MCLK;
    assign ROMEN     = (state == SEND);
    assign dbg_state = state;

    // Subtracting first keeps the window check free of BASE_ADDR+ROM_BYTES overflow.
    assign off      = BR_ADDR - BASE_ADDR;
    assign in_range = (BR_ADDR >= BASE_ADDR) && (off < ROM_BYTES);
    assign pop_now  = (state == POP);
    // POP is only ever entered with a word available, so pop_now means a real pop.
    assign push_ok      = BR_WR && in_range && (DL_START || !full || pop_now);
    assign overflow_evt = BR_WR && in_range && !DL_START && full && !pop_now;
    assign gap_last     = (int'(gap_cnt) == BYTE_GAP - 1);

    gaplus_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (MCLK),
        .rst   (RESET),
        .flush (DL_START),
        .push  (BR_WR && in_range),
        .wdata ({off[ROM_AW-1:2], BR_DATA}),
        .pop   (pop_now && !DL_START),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    // Next-state logic. IDLE looks at the incoming push too, so the first strobe lands
    // two cycles after a push into an empty FIFO.
    always_comb begin
        state_next = state;
        k_next     = k;
        load_byte  = 1'b0;
        case (state)
            IDLE: if (!empty || push_ok) state_next = POP;
            POP: begin
                state_next = SEND;
                k_next     = 2'd0;
                load_byte  = 1'b1;
            end
            SEND: begin
                if (BYTE_GAP != 0) begin
                    state_next = GAP;
                end else if (k == 2'd3) begin
                    state_next = empty ? IDLE : POP;
                end else begin
                    k_next    = k + 2'd1;
                    load_byte = 1'b1;
                end
            end
            GAP: begin
                if (gap_last) begin
                    if (k == 2'd3) begin
                        state_next = empty ? IDLE : POP;
                    end else begin
                        state_next = SEND;
                        k_next     = k + 2'd1;
                        load_byte  = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (DL_START) begin
            state_next = IDLE;
            k_next     = 2'd0;
            load_byte  = 1'b0;
        end
    end

    // In POP the holding register is being loaded on this same edge, so the first byte
    // comes straight from the FIFO head.
    assign src = pop_now ? head : hold;

    always_comb begin
        byte_next = 8'h00;
        case (k_next)
            2'd0: byte_next = src[31:24];
            2'd1: byte_next = src[23:16];
            2'd2: byte_next = src[15:8];
            2'd3: byte_next = src[7:0];
            default: byte_next = 8'h00;
        endcase
    end

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            k       <= 2'd0;
            gap_cnt <= '0;
            hold    <= '0;
            ROMAD   <= '0;
            ROMDT   <= 8'h00;
        end else begin
            state <= state_next;
            k     <= k_next;
            if (state == GAP && !gap_last && !DL_START) gap_cnt <= gap_cnt + GW'(1);
            else                                        gap_cnt <= '0;
            if (pop_now) hold <= head;
            if (load_byte) begin
                ROMAD <= {src[EW-1:32], k_next};
                ROMDT <= byte_next;
            end
        end
    end

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            DL_ACTIVE <= 1'b0;
            DL_DONE   <= 1'b0;
            OVERFLOW  <= 1'b0;
            end_flag  <= 1'b0;
        end else if (DL_START) begin
            DL_ACTIVE <= 1'b1;
            DL_DONE   <= 1'b0;
            OVERFLOW  <= 1'b0;
            end_flag  <= 1'b0;
        end else begin
            if (overflow_evt)         OVERFLOW <= 1'b1;
            if (DL_END && DL_ACTIVE)  end_flag <= 1'b1;
            if (end_flag && empty && state == IDLE) begin
                DL_DONE   <= 1'b1;
                DL_ACTIVE <= 1'b0;
                end_flag  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_gaplus_rom_sender.sv
module tb_gaplus_rom_sender;
    import gaplus_pkg::*;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int unsigned RB   = 262144;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        br_wr = 1'b0, dl_start = 1'b0, dl_end = 1'b0;
    logic [31:0] br_addr = '0, br_data = '0;

    // main DUT, BYTE_GAP = 3
    logic        romcl, romen, act, done, ovf;
    logic [17:0] romad;
    logic [7:0]  romdt;
    state_t      st;
    // second DUT, BYTE_GAP = 0
    logic        romcl0, romen0, act0, done0, ovf0;
    logic [17:0] romad0;
    logic [7:0]  romdt0;
    state_t      st0;

    gaplus_rom_sender #(.FIFO_DEPTH(16), .BASE_ADDR(BASE), .ROM_BYTES(RB), .BYTE_GAP(3)) dut (
        .MCLK(clk), .RESET(rst), .BR_WR(br_wr), .BR_ADDR(br_addr), .BR_DATA(br_data),
        .DL_START(dl_start), .DL_END(dl_end), .ROMCL(romcl), .ROMAD(romad), .ROMDT(romdt),
        .ROMEN(romen), .DL_ACTIVE(act), .DL_DONE(done), .OVERFLOW(ovf), .dbg_state(st));

    gaplus_rom_sender #(.FIFO_DEPTH(16), .BASE_ADDR(BASE), .ROM_BYTES(RB), .BYTE_GAP(0)) dut0 (
        .MCLK(clk), .RESET(rst), .BR_WR(br_wr), .BR_ADDR(br_addr), .BR_DATA(br_data),
        .DL_START(dl_start), .DL_END(dl_end), .ROMCL(romcl0), .ROMAD(romad0), .ROMDT(romdt0),
        .ROMEN(romen0), .DL_ACTIVE(act0), .DL_DONE(done0), .OVERFLOW(ovf0), .dbg_state(st0));

    // scoreboard: captured strobes and expected {ROMAD, ROMDT}
    int          checks = 0;
    int          errors = 0;
    int          cap_cyc[$];
    logic [25:0] cap_q[$];
    int          z_cyc[$];
    logic [25:0] z_q[$];
    logic [25:0] exp_q[$];

    always @(negedge clk) begin
        if (romen === 1'b1) begin
            cap_cyc.push_back(cyc);
            cap_q.push_back({romad, romdt});
        end
        if (romen0 === 1'b1) begin
            z_cyc.push_back(cyc);
            z_q.push_back({romad0, romdt0});
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_caps();
        cap_cyc.delete(); cap_q.delete(); z_cyc.delete(); z_q.delete(); exp_q.delete();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        br_wr = 1'b1; br_addr = a; br_data = d;
        tick(1);
        br_wr = 1'b0;
    endtask

    task automatic pulse_start();
        dl_start = 1'b1;
        tick(1);
        dl_start = 1'b0;
    endtask

    task automatic exp_word(input logic [31:0] offs, input logic [31:0] d);
        for (int k = 0; k < 4; k++) exp_q.push_back({offs[17:2], k[1:0], d[31-8*k -: 8]});
    endtask

    // tests
    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        @(negedge clk);
        checks++; if (romen !== 1'b0)  begin errors++; $display("FAIL reset_romen got %b exp 0", romen); end
        checks++; if (romad !== 18'h0) begin errors++; $display("FAIL reset_romad got %h exp 0", romad); end
        checks++; if (romdt !== 8'h0)  begin errors++; $display("FAIL reset_romdt got %h exp 0", romdt); end
        checks++; if ({act, done, ovf} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {act, done, ovf}); end
        checks++; if (st !== IDLE)     begin errors++; $display("FAIL reset_state got %0d exp 0", st); end
        checks++; if (romcl !== 1'b0)  begin errors++; $display("FAIL romcl_copy got %b exp 0", romcl); end
        @(posedge clk); #1;
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_single();
        int w;
        clear_caps();
        w = cyc;
        wr(BASE + 32'h100, 32'hA1B2_C3D4);
        exp_word(32'h100, 32'hA1B2_C3D4);
        tick(24);
        checks++; if (cap_q.size() != 4) begin errors++; $display("FAIL single_count got %0d exp 4", cap_q.size()); end
        for (int i = 0; i < 4 && i < cap_q.size(); i++) begin
            checks++; if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_byte%0d got %h exp %h", i, cap_q[i], exp_q[i]); end
            checks++; if (cap_cyc[i] != w + 2 + 4 * i) begin errors++; $display("FAIL single_time%0d got %0d exp %0d", i, cap_cyc[i], w + 2 + 4 * i); end
        end
    endtask

    task automatic test_range();
        int w;
        clear_caps();
        wr(BASE + RB, 32'hDEAD_0001);
        wr(BASE - 32'd4, 32'hDEAD_0002);
        tick(20);
        checks++; if (cap_q.size() != 0) begin errors++; $display("FAIL range_ignored got %0d strobes exp 0", cap_q.size()); end
        checks++; if (ovf !== 1'b0)      begin errors++; $display("FAIL range_ovf got %b exp 0", ovf); end
        checks++; if (st !== IDLE)       begin errors++; $display("FAIL range_state got %0d exp 0", st); end
        w = cyc;
        wr(BASE + RB - 32'd4, 32'h0F1E_2D3C);
        exp_word(32'h3FFFC, 32'h0F1E_2D3C);
        tick(24);
        checks++; if (cap_q.size() != 4) begin errors++; $display("FAIL range_top_count got %0d exp 4", cap_q.size()); end
        for (int i = 0; i < 4 && i < cap_q.size(); i++) begin
            checks++; if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL range_top_byte%0d got %h exp %h", i, cap_q[i], exp_q[i]); end
        end
        checks++; if (cap_cyc.size() > 0 && cap_cyc[0] != w + 2) begin errors++; $display("FAIL range_top_time got %0d exp %0d", cap_cyc[0], w + 2); end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        pulse_start();
        clear_caps();
        for (int i = 0; i < 18; i++) begin
            d = {8'hC0, 8'(i), 8'hDE, 8'(i * 3)};
            if (i < 17) exp_word(32'h200 + 32'(4 * i), d);
            wr(BASE + 32'h200 + 32'(4 * i), d);
        end
        @(negedge clk);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", ovf); end
        tick(300);
        checks++; if (cap_q.size() != 68) begin errors++; $display("FAIL ovf_count got %0d exp 68", cap_q.size()); end
        for (int i = 0; i < 68 && i < cap_q.size(); i++) begin
            checks++; if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_byte%0d got %h exp %h", i, cap_q[i], exp_q[i]); end
        end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", ovf); end
        pulse_start();
        @(negedge clk);
        checks++; if ({ovf, act} !== 2'b01) begin errors++; $display("FAIL ovf_clear got ovf,act=%b exp 01", {ovf, act}); end
        tick(1);
    endtask

    task automatic test_download();
        int done_cyc;
        pulse_start();
        clear_caps();
        for (int i = 0; i < 8; i++) begin
            exp_word(32'h1000 + 32'(4 * i), {8'(i), 8'(i + 16), 8'(i + 32), 8'(i + 48)});
            wr(BASE + 32'h1000 + 32'(4 * i), {8'(i), 8'(i + 16), 8'(i + 32), 8'(i + 48)});
        end
        dl_end = 1'b1;
        tick(1);
        dl_end = 1'b0;
        @(negedge clk);
        checks++; if ({act, done} !== 2'b10) begin errors++; $display("FAIL dl_midway got act,done=%b exp 10", {act, done}); end
        for (int n = 0; n < 400 && done !== 1'b1; n++) @(negedge clk);
        done_cyc = cyc;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL dl_done_timeout got %b exp 1", done); end
        checks++; if (act !== 1'b0)  begin errors++; $display("FAIL dl_active_fall got %b exp 0", act); end
        checks++; if (cap_q.size() != 32) begin errors++; $display("FAIL dl_count got %0d exp 32", cap_q.size()); end
        for (int i = 0; i < 32 && i < cap_q.size(); i++) begin
            checks++; if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL dl_byte%0d got %h exp %h", i, cap_q[i], exp_q[i]); end
        end
        if (cap_cyc.size() == 32) begin
            checks++; if (done_cyc != cap_cyc[31] + 5) begin errors++; $display("FAIL dl_done_time got %0d exp %0d", done_cyc, cap_cyc[31] + 5); end
        end
        tick(1);
    endtask

    task automatic test_abort();
        int w;
        clear_caps();
        w = cyc;
        for (int i = 0; i < 18; i++) wr(BASE + 32'h2000 + 32'(4 * i), 32'h1122_3344 + 32'(i));
        exp_word(32'h2000, 32'h1122_3344);
        exp_q.push_back({18'h02004, 8'h11});
        exp_q.push_back({18'h02005, 8'h22});
        tick(4);
        @(negedge clk);
        checks++; if ({ovf, done} !== 2'b11) begin errors++; $display("FAIL abort_pre got ovf,done=%b exp 11", {ovf, done}); end
        @(posedge clk); #1;
        // cycle w+23 is SEND k=1 of the second word
        dl_start = 1'b1;
        tick(1);
        dl_start = 1'b0;
        tick(40);
        checks++; if (cap_q.size() != 6) begin errors++; $display("FAIL abort_count got %0d exp 6", cap_q.size()); end
        for (int i = 0; i < 6 && i < cap_q.size(); i++) begin
            checks++; if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL abort_byte%0d got %h exp %h", i, cap_q[i], exp_q[i]); end
        end
        checks++; if (cap_cyc.size() == 6 && cap_cyc[5] != w + 23) begin errors++; $display("FAIL abort_time got %0d exp %0d", cap_cyc[5], w + 23); end
        checks++; if ({ovf, done, act} !== 3'b001) begin errors++; $display("FAIL abort_flags got ovf,done,act=%b exp 001", {ovf, done, act}); end
        checks++; if (st !== IDLE) begin errors++; $display("FAIL abort_state got %0d exp 0", st); end
    endtask

    task automatic test_gap0();
        int rel [8] = '{0, 1, 2, 3, 5, 6, 7, 8};
        clear_caps();
        // write in the same cycle as DL_START must survive the flush
        dl_start = 1'b1; br_wr = 1'b1; br_addr = BASE + 32'h300; br_data = 32'hDEAD_BEEF;
        tick(1);
        dl_start = 1'b0; br_addr = BASE + 32'h304; br_data = 32'h0123_4567;
        tick(1);
        br_wr = 1'b0;
        exp_word(32'h300, 32'hDEAD_BEEF);
        exp_word(32'h304, 32'h0123_4567);
        tick(20);
        checks++; if (z_q.size() != 8) begin errors++; $display("FAIL gap0_count got %0d exp 8", z_q.size()); end
        for (int i = 0; i < 8 && i < z_q.size(); i++) begin
            checks++; if (z_q[i] !== exp_q[i]) begin errors++; $display("FAIL gap0_byte%0d got %h exp %h", i, z_q[i], exp_q[i]); end
            checks++; if (z_cyc[i] - z_cyc[0] != rel[i]) begin errors++; $display("FAIL gap0_time%0d got +%0d exp +%0d", i, z_cyc[i] - z_cyc[0], rel[i]); end
        end
    endtask

    task automatic test_reset_mid();
        clear_caps();
        wr(BASE + 32'h400, 32'h5566_7788);
        for (int n = 0; n < 10 && romen !== 1'b1; n++) @(negedge clk);
        checks++; if (romen !== 1'b1) begin errors++; $display("FAIL rstmid_start got %b exp 1", romen); end
        #2 rst = 1'b1;
        #1;
        checks++; if (romen !== 1'b0) begin errors++; $display("FAIL rstmid_async got %b exp 0", romen); end
        tick(2);
        rst = 1'b0;
        tick(30);
        checks++; if (cap_q.size() != 1) begin errors++; $display("FAIL rstmid_count got %0d exp 1", cap_q.size()); end
        checks++; if ({romad, romdt} !== 26'h0) begin errors++; $display("FAIL rstmid_bus got %h exp 0", {romad, romdt}); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_range();
        test_overflow();
        test_download();
        test_abort();
        test_gap0();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
